// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: Wishbone slave bus and interrupt line for uart_tx_fifo
// Ports (signals):
//   uart_stb_i, uart_we_i, uart_adr_i[1:0], uart_dat_i  - master to slave request
//   uart_dat_o, uart_ack_o, uart_err_o                  - slave response
//   uart_irq_o                                          - slave level interrupt
interface uart_tx_fifo_if #(
  parameter int DAT_WIDTH = 64
);
  logic                 uart_stb_i;
  logic                 uart_we_i;
  logic [1:0]           uart_adr_i;
  logic [DAT_WIDTH-1:0] uart_dat_i;
  logic [DAT_WIDTH-1:0] uart_dat_o;
  logic                 uart_ack_o;
  logic                 uart_err_o;
  logic                 uart_irq_o;
  modport master (
    output uart_stb_i, uart_we_i, uart_adr_i, uart_dat_i,
    input  uart_dat_o, uart_ack_o, uart_err_o, uart_irq_o
  );
  modport slave (
    input  uart_stb_i, uart_we_i, uart_adr_i, uart_dat_i,
    output uart_dat_o, uart_ack_o, uart_err_o, uart_irq_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: Wishbone-slave UART transmitter with TX FIFO, baud divisor and frame format
// Ports:
//   clk_i     - system clock, rising edge
//   rst_i     - synchronous active-high reset
//   bus       - Wishbone slave (TXDATA/STATUS/CTRL/DIVISOR) plus level interrupt
//   uart_out  - last byte accepted into the FIFO
//   uart_tx   - serial line, idle high
module uart_tx_fifo #(
  parameter int DAT_WIDTH   = 64,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 868,
  parameter int DIV_WIDTH   = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  uart_tx_fifo_if.slave bus,
  output logic [7:0]    uart_out,
  output logic          uart_tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q;
  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [CW-1:0]        cnt_q;
  logic [DIV_WIDTH-1:0] div_q, baud_q;
  logic [6:0]           ctrl_q;
  logic [DAT_WIDTH-1:0] rdata_q, rdata_d;
  logic [7:0]           out_q, shift_q;
  logic [2:0]           bit_q;
  logic [1:0]           nbits_q, par_mode_q;
  logic                 ack_q, err_q, irq_q, tx_q, stop2_q, stop_cnt_q, par_q;
  logic                 acc, wr, bad, push, pop, flush, div_wr, tick;
  logic                 empty, full, busy, frame_end, last_bit, par_en;
  logic                 unused_ok;
  always_comb begin
    empty     = cnt_q == '0;
    full      = cnt_q == CW'(FIFO_DEPTH);
    busy      = state_q != IDLE;
    acc       = bus.uart_stb_i && !ack_q && !err_q;
    wr        = acc && bus.uart_we_i;
    // full is judged on the pre-pop count so a same-cycle pop cannot rescue a push
    bad       = wr && (bus.uart_adr_i == 2'd1 || (bus.uart_adr_i == 2'd0 && full));
    push      = wr && bus.uart_adr_i == 2'd0 && !full;
    flush     = wr && bus.uart_adr_i == 2'd2 && bus.uart_dat_i[7];
    div_wr    = wr && bus.uart_adr_i == 2'd3;
    tick      = baud_q == div_q;
    frame_end = state_q == STOP && (!stop2_q || stop_cnt_q);
    pop       = tick && ctrl_q[5] && !empty && (state_q == IDLE || frame_end);
    // last data bit index is nbits+4, i.e. {1, nbits}
    last_bit  = bit_q == {1'b1, nbits_q};
    par_en    = ^par_mode_q;
    rdata_d   = bus.uart_adr_i == 2'd1 ? DAT_WIDTH'({8'(cnt_q), 5'b0, busy, full, empty}) :
                bus.uart_adr_i == 2'd2 ? DAT_WIDTH'(ctrl_q) :
                bus.uart_adr_i == 2'd3 ? DAT_WIDTH'(div_q) : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      div_q      <= DIV_WIDTH'(DEFAULT_DIV - 1);
      baud_q     <= '0;
      ctrl_q     <= 7'h23;
      rdata_q    <= '0;
      out_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      nbits_q    <= '0;
      par_mode_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
      tx_q       <= 1'b1;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      ack_q   <= acc && !bad;
      err_q   <= acc && bad;
      rdata_q <= rdata_d;
      irq_q   <= ctrl_q[6] && empty && !busy;
      baud_q  <= (div_wr || tick) ? '0 : baud_q + 1'b1;
      if (div_wr) div_q <= bus.uart_dat_i[DIV_WIDTH-1:0];
      if (wr && bus.uart_adr_i == 2'd2) ctrl_q <= bus.uart_dat_i[6:0];
      if (push) begin
        mem_q[wr_q] <= bus.uart_dat_i[7:0];
        wr_q        <= wr_q + 1'b1;
        out_q       <= bus.uart_dat_i[7:0];
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (flush) rd_q <= wr_q;
      cnt_q <= flush ? '0 : cnt_q + CW'(push) - CW'(pop);
      if (tick) begin
        if (pop) begin
          shift_q    <= mem_q[rd_q];
          nbits_q    <= ctrl_q[1:0];
          par_mode_q <= ctrl_q[3:2];
          stop2_q    <= ctrl_q[4];
          tx_q       <= 1'b0;
          state_q    <= START;
        end else begin
          case (state_q)
            START: begin
              tx_q    <= shift_q[0];
              par_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= '0;
              state_q <= DATA;
            end
            DATA: begin
              if (last_bit) begin
                tx_q       <= par_en ? par_q ^ par_mode_q[1] : 1'b1;
                stop_cnt_q <= 1'b0;
                state_q    <= par_en ? PARITY : STOP;
              end else begin
                tx_q    <= shift_q[0];
                par_q   <= par_q ^ shift_q[0];
                shift_q <= shift_q >> 1;
                bit_q   <= bit_q + 1'b1;
              end
            end
            PARITY: begin
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= STOP;
            end
            STOP: begin
              if (frame_end) state_q <= IDLE;
              else stop_cnt_q <= 1'b1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end
  assign bus.uart_ack_o = ack_q && bus.uart_stb_i;
  assign bus.uart_err_o = err_q && bus.uart_stb_i;
  assign bus.uart_dat_o = (ack_q && bus.uart_stb_i) ? rdata_q : '0;
  assign bus.uart_irq_o = irq_q;
  assign uart_out       = out_q;
  assign uart_tx        = tx_q;
  assign unused_ok      = ^bus.uart_dat_i[DAT_WIDTH-1:DIV_WIDTH];
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] uart_out;
  logic       uart_tx;
  int         n_chk = 0;
  int         n_fail = 0;
  uart_tx_fifo_if #(.DAT_WIDTH(64)) bus ();
  uart_tx_fifo #(.DAT_WIDTH(64), .FIFO_DEPTH(16), .DEFAULT_DIV(868), .DIV_WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .uart_out(uart_out),
    .uart_tx (uart_tx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic acc(input logic we, input logic [1:0] adr, input logic [63:0] d,
                     output logic [63:0] r, output logic [1:0] resp, output int lat);
    bus.uart_stb_i = 1'b1;
    bus.uart_we_i  = we;
    bus.uart_adr_i = adr;
    bus.uart_dat_i = d;
    lat = 0;
    @(negedge clk);
    while (bus.uart_ack_o !== 1'b1 && bus.uart_err_o !== 1'b1 && lat < 4) begin
      @(negedge clk);
      lat++;
    end
    r    = bus.uart_dat_o;
    resp = {bus.uart_ack_o, bus.uart_err_o};
    bus.uart_stb_i = 1'b0;
    bus.uart_we_i  = 1'b0;
    @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] adr, input logic [63:0] d, input logic [1:0] exp_resp, input string tag);
    logic [63:0] r;
    logic [1:0]  resp;
    int          lat;
    acc(1'b1, adr, d, r, resp, lat);
    chk(tag, 128'({resp, 32'(lat)}), 128'({exp_resp, 32'd0}));
  endtask
  task automatic rd(input logic [1:0] adr, input logic [63:0] exp, input string tag);
    logic [63:0] r;
    logic [1:0]  resp;
    int          lat;
    acc(1'b0, adr, 64'd0, r, resp, lat);
    chk(tag, 128'({resp, 32'(lat), r}), 128'({2'b10, 32'd0, exp}));
  endtask
  // exp holds the line bits in send order from bit 0 (start) upward
  task automatic frame(input logic [11:0] exp, input int n, input int hold, input int max_gap, input string tag);
    int         t = 0;
    logic [3:0] seen;
    while (uart_tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_gap"}, 128'(t <= max_gap), 128'(1'b1));
    for (int i = 0; i < n; i++) begin
      seen = '0;
      for (int c = 0; c < hold; c++) begin
        seen[c] = uart_tx;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, i), 128'(seen), 128'(exp[i] ? 4'((1 << hold) - 1) : 4'h0));
    end
  endtask
  initial begin
    logic [63:0] r;
    logic [1:0]  resp;
    int          lat;
    int          k;
    bus.uart_stb_i = 1'b0;
    bus.uart_we_i  = 1'b0;
    bus.uart_adr_i = 2'd0;
    bus.uart_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 128'({uart_tx, bus.uart_ack_o, bus.uart_err_o, bus.uart_irq_o, uart_out, bus.uart_dat_o}),
        128'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0}));
    rst = 1'b0;
    rd(2'd1, 64'h0001, "rst_status");
    rd(2'd2, 64'h0023, "rst_ctrl");
    rd(2'd3, 64'd867, "rst_div");
    chk("rst_line", 128'(uart_tx), 128'(1'b1));
    wr(2'd3, 64'd3, 2'b10, "div3");
    rd(2'd3, 64'd3, "div3_rb");
    wr(2'd0, 64'h55, 2'b10, "tx55");
    chk("out55", 128'(uart_out), 128'(8'h55));
    frame(12'({1'b1, 8'h55, 1'b0}), 10, 4, 8, "f55");
    rd(2'd1, 64'h0001, "idle55");
    wr(2'd2, 64'h26, 2'b10, "ctrl_7e1");
    wr(2'd0, 64'h07, 2'b10, "tx07e");
    frame(12'({1'b1, 1'b1, 7'h07, 1'b0}), 10, 4, 8, "f07e");
    wr(2'd2, 64'h2A, 2'b10, "ctrl_7o1");
    wr(2'd0, 64'h07, 2'b10, "tx07o");
    frame(12'({1'b1, 1'b0, 7'h07, 1'b0}), 10, 4, 8, "f07o");
    wr(2'd1, 64'h0, 2'b01, "wr_status_err");
    rd(2'd0, 64'h0, "rd_txdata_zero");
    wr(2'd2, 64'h03, 2'b10, "ctrl_txoff");
    for (int i = 0; i < 16; i++) wr(2'd0, 64'(8'hA0 + i), 2'b10, $sformatf("fill%0d", i));
    wr(2'd0, 64'hEE, 2'b01, "fill_overflow");
    chk("out_after_ovf", 128'(uart_out), 128'(8'hAF));
    rd(2'd1, 64'h1002, "status_full");
    chk("line_idle_txoff", 128'(uart_tx), 128'(1'b1));
    wr(2'd2, 64'h23, 2'b10, "ctrl_txon");
    for (int i = 0; i < 16; i++)
      frame(12'({1'b1, 8'(8'hA0 + i), 1'b0}), 10, 4, (i == 0) ? 8 : 0, $sformatf("b2b%0d", i));
    rd(2'd1, 64'h0001, "status_drained");
    wr(2'd2, 64'h63, 2'b10, "ctrl_ie");
    chk("irq_idle", 128'(bus.uart_irq_o), 128'(1'b1));
    wr(2'd0, 64'h3C, 2'b10, "tx3c");
    chk("irq_busy", 128'(bus.uart_irq_o), 128'(1'b0));
    frame(12'({1'b1, 8'h3C, 1'b0}), 10, 4, 8, "f3c");
    @(negedge clk);
    chk("irq_done", 128'(bus.uart_irq_o), 128'(1'b1));
    for (int i = 0; i < 6; i++) wr(2'd0, 64'(8'h10 + i), 2'b10, $sformatf("q%0d", i));
    rd(2'd1, 64'h0504, "status_q5");
    wr(2'd2, 64'hE3, 2'b10, "flush");
    rd(2'd1, 64'h0005, "status_flushed");
    rd(2'd2, 64'h63, "ctrl_flush_reads0");
    r = '1;
    k = 0;
    while (r !== 64'h1 && k < 40) begin
      acc(1'b0, 2'd1, 64'd0, r, resp, lat);
      k++;
    end
    chk("flush_frame_done", 128'(r), 128'(64'h1));
    chk("flush_no_abort", 128'(k > 3), 128'(1'b1));
    repeat (20) @(negedge clk);
    chk("line_idle_after_flush", 128'({uart_tx, bus.uart_irq_o}), 128'(2'b11));
    wr(2'd2, 64'h23, 2'b10, "ctrl_ie_off");
    wr(2'd3, 64'd0, 2'b10, "div0");
    wr(2'd0, 64'h0F, 2'b10, "tx0f");
    frame(12'({1'b1, 8'h0F, 1'b0}), 10, 1, 4, "fdiv0");
    wr(2'd3, 64'd3, 2'b10, "div3_again");
    wr(2'd0, 64'h00, 2'b10, "tx00");
    wr(2'd0, 64'h99, 2'b10, "tx99_queued");
    k = 0;
    while (uart_tx !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (6) @(negedge clk);
    chk("mid_data_low", 128'(uart_tx), 128'(1'b0));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_frame_line", 128'(uart_tx), 128'(1'b1));
    rst = 1'b0;
    rd(2'd1, 64'h0001, "rst2_status");
    rd(2'd2, 64'h0023, "rst2_ctrl");
    rd(2'd3, 64'd867, "rst2_div");
    chk("rst2_out", 128'({uart_out, uart_tx}), 128'({8'h00, 1'b1}));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
